// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared state encoding, default widths and helpers for ram_arbiter
package ram_ctrl_pkg;

    localparam int D_WIDTH_DEF = 16;
    localparam int A_WIDTH_DEF = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Requester index to its one-hot position in the 2-bit request/response vectors.
    function automatic logic [1:0] id_mask(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - two-requester request/response bus between clients and ram_arbiter
interface ram_arbiter_if
    import ram_ctrl_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_we;
    logic [2*A_WIDTH-1:0] req_addr;
    logic [2*D_WIDTH-1:0] req_wdata;
    logic [1:0]           rsp_valid;
    logic [D_WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with a pointer that moves only on a grant
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr = 0 favours requester 0, ptr = 1 favours requester 1
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - clears the RAM after reset, then arbitrates two requesters onto its ports
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_arbiter_if.slave       bus,
    output logic               init_done,
    output logic [A_WIDTH-1:0] ram_address_write,
    output logic [D_WIDTH-1:0] ram_data_write,
    output logic               ram_write_enable,
    output logic [A_WIDTH-1:0] ram_address_read,
    input  logic [D_WIDTH-1:0] ram_data_read
);

    state_e             state;
    state_e             state_nxt;
    logic [A_WIDTH-1:0] clr_cnt;
    logic               clr_last;
    logic               clr_en;
    logic               run_en;

    logic [1:0]         grant;
    logic               gnt_id;
    logic               accepted;
    logic               sel_we;
    logic [A_WIDTH-1:0] sel_addr;
    logic [D_WIDTH-1:0] sel_wdata;

    logic               rd_v1;
    logic               rd_id1;
    logic               rd_v2;
    logic               rd_id2;

    assign clr_last = &clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && clr_last) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        clr_en    = (state == INIT);
        run_en    = (state == RUN);
        init_done = (state == RUN);
    end

    // Counter parks on the last address instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (clr_en && !clr_last) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_en),
        .req   (bus.req_valid),
        .gnt   (grant)
    );

    assign bus.req_ready = grant;
    assign accepted      = |grant;
    assign gnt_id        = grant[1];
    assign sel_we        = gnt_id ? bus.req_we[1] : bus.req_we[0];
    assign sel_addr      = gnt_id ? bus.req_addr[2*A_WIDTH-1:A_WIDTH] : bus.req_addr[A_WIDTH-1:0];
    assign sel_wdata     = gnt_id ? bus.req_wdata[2*D_WIDTH-1:D_WIDTH] : bus.req_wdata[D_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_write_enable  <= 1'b0;
            ram_address_write <= '0;
            ram_data_write    <= '0;
        end else if (clr_en) begin
            ram_write_enable  <= 1'b1;
            ram_address_write <= clr_cnt;
            ram_data_write    <= '0;
        end else begin
            ram_write_enable <= accepted && sel_we;
            if (accepted && sel_we) begin
                ram_address_write <= sel_addr;
                ram_data_write    <= sel_wdata;
            end
        end
    end

    // Stage 1 drives the RAM read address, stage 2 lines up with the registered RAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1            <= 1'b0;
            rd_id1           <= 1'b0;
            rd_v2            <= 1'b0;
            rd_id2           <= 1'b0;
            ram_address_read <= '0;
        end else begin
            rd_v1  <= accepted && !sel_we;
            rd_id1 <= gnt_id;
            rd_v2  <= rd_v1;
            rd_id2 <= rd_id1;
            if (accepted && !sel_we) begin
                ram_address_read <= sel_addr;
            end
        end
    end

    assign bus.rsp_valid = rd_v2 ? id_mask(rd_id2) : 2'b00;
    assign bus.rsp_rdata = rd_v2 ? ram_data_read : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized directed bench for ram_arbiter against a queue-based model
module tb_ram_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_done;
    logic          ram_write_enable;
    logic [AW-1:0] ram_address_write;
    logic [AW-1:0] ram_address_read;
    logic [DW-1:0] ram_data_write;
    logic [DW-1:0] ram_data_read;

    always #5 clk = ~clk;

    ram_arbiter_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

    ram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .init_done         (init_done),
        .ram_address_write (ram_address_write),
        .ram_data_write    (ram_data_write),
        .ram_write_enable  (ram_write_enable),
        .ram_address_read  (ram_address_read),
        .ram_data_read     (ram_data_read)
    );

    // Synchronous RAM; scrambled while reset is held so the clear is observable.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DW'($urandom);
        end else if (ram_write_enable) begin
            ram[ram_address_write] <= ram_data_write;
        end
        ram_data_read <= ram[ram_address_read];
    end

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    rd_t           rdq[$];
    wr_t           wrq[$];
    logic [DW-1:0] mem_m [DEPTH];
    int            last_gnt;
    int            cyc;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rdq.delete();
        wrq.delete();
        last_gnt = 1;
        cyc      = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [1:0]    exp_rdy;
        logic [1:0]    exp_rv;
        logic [DW-1:0] exp_rd;
        logic          exp_we;
        logic [AW-1:0] exp_wa;
        logic [DW-1:0] exp_wd;
        logic [AW-1:0] a;
        int            w;
        rd_t           r;
        wr_t           wr;

        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
        @(negedge clk);

        exp_rdy = 2'b00;
        w       = -1;
        if (cyc >= DEPTH) begin
            if (v == 2'b11)  w = 1 - last_gnt;
            else if (v[0])   w = 0;
            else if (v[1])   w = 1;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check("init_done", 64'(init_done), 64'(cyc >= DEPTH));

        exp_we = 1'b0;
        exp_wa = '0;
        exp_wd = '0;
        if (cyc >= 1 && cyc <= DEPTH) begin
            exp_we = 1'b1;
            exp_wa = AW'(cyc - 1);
        end else if (wrq.size() > 0 && wrq[0].due == cyc) begin
            exp_we = 1'b1;
            exp_wa = wrq[0].a;
            exp_wd = wrq[0].d;
            void'(wrq.pop_front());
        end
        check("ram_write_enable", 64'(ram_write_enable), 64'(exp_we));
        if (exp_we) begin
            check("ram_address_write", 64'(ram_address_write), 64'(exp_wa));
            check("ram_data_write", 64'(ram_data_write), 64'(exp_wd));
        end

        exp_rv = 2'b00;
        exp_rd = '0;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            exp_rv[rdq[0].id] = 1'b1;
            exp_rd = rdq[0].data;
            void'(rdq.pop_front());
        end
        check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (exp_rv != 2'b00) check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));

        if (w >= 0) begin
            last_gnt = w;
            a = (w == 1) ? a1 : a0;
            if (we[w]) begin
                mem_m[a] = (w == 1) ? d1 : d0;
                wr.due = cyc + 1;
                wr.a   = a;
                wr.d   = mem_m[a];
                wrq.push_back(wr);
            end else begin
                r.due  = cyc + 2;
                r.id   = w;
                r.data = mem_m[a];
                rdq.push_back(r);
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    task automatic rand_steps(input int n, input logic force_both);
        for (int i = 0; i < n; i++)
            step(force_both ? 2'b11 : 2'($urandom), 2'($urandom),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                 DW'($urandom), DW'($urandom));
    endtask

    task automatic do_reset();
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check("rst req_ready", 64'(bus.req_ready), 64'd0);
        check("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst init_done", 64'(init_done), 64'd0);
        check("rst ram_write_enable", 64'(ram_write_enable), 64'd0);
        check("rst ram_address_write", 64'(ram_address_write), 64'd0);
        check("rst ram_data_write", 64'(ram_data_write), 64'd0);
        check("rst ram_address_read", 64'(ram_address_read), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Clear phase with both requesters pushing
        do_reset();
        rand_steps(DEPTH, 1'b1);

        // Read of the top address straight after the clear
        step(2'b01, 2'b00, AW'(31), '0, '0, '0);
        idle(3);

        // Write then read-after-write on requester 0
        step(2'b01, 2'b01, AW'(5), '0, 16'hBEEF, '0);
        step(2'b01, 2'b00, AW'(5), '0, '0, '0);
        idle(3);

        // Requester 1 wins last, so the contended reads start with requester 0
        step(2'b10, 2'b10, '0, AW'(7), '0, 16'h1234);
        for (int i = 0; i < 4; i++)
            step(2'b11, 2'b00, AW'($urandom_range(0, 7)), AW'($urandom_range(5, 7)), '0, '0);
        idle(3);

        rand_steps(300, 1'b0);
        idle(3);

        // Reset while a read is in flight
        step(2'b01, 2'b00, AW'(5), '0, '0, '0);
        do_reset();
        rand_steps(DEPTH + 2, 1'b1);
        rand_steps(60, 1'b0);
        idle(3);

        // Reset part-way through the clear
        do_reset();
        rand_steps(10, 1'b1);
        do_reset();
        rand_steps(DEPTH, 1'b1);
        rand_steps(60, 1'b0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
